int_to_fp: RTL

Multi-cycle converter from 32-bit integer (signed or unsigned) to IEEE-754 single precision, round-to-nearest-even. It produces the operand format consumed by the floating-point add/sub unit. It uses the same start/done handshake style as the rest of the FP datapath. Normalization is iterative: one left shift per cycle, so latency is data-dependent.

---
 rtl/int_to_fp.sv | 138 +++++++++++++
 1 files changed

// File: rtl/int_to_fp.sv
// int_to_fp: multi-cycle 32-bit integer (signed or unsigned) to IEEE-754
// binary32 converter, round-to-nearest-even. Normalisation shifts one bit
// per cycle, so latency depends on the leading-zero count of the magnitude
// (lz + 3 edges after start is sampled; 1 edge for a zero operand).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   a          integer operand, sampled with start in IDLE
//   is_signed  1: a is two's complement, 0: unsigned; sampled with a
//   start      conversion request, accepted only in IDLE
//   result     {sign, exp[7:0], mant[22:0]}, updated only when done is set
//   done       one-cycle pulse marking a new result
//   busy       high in every state except IDLE
module int_to_fp (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic        is_signed,
  input  logic        start,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ABS,
    S_NORM,
    S_ROUND
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic        sgnin_q, sgnin_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_q, exp_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  logic [31:0] mag_abs;
  logic        round_up;
  logic [24:0] mant_sum;
  logic [7:0]  exp_rnd;

  // Two's complement negation; -2^31 maps onto itself, which is the
  // correct unsigned magnitude 0x80000000.
  assign mag_abs  = (sgnin_q & mag_q[31]) ? (~mag_q + 32'd1) : mag_q;

  // Nearest-even: guard set and (sticky or LSB of the kept mantissa).
  assign round_up = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
  // Hidden bit included so a carry out of it lands in bit 24.
  assign mant_sum = {1'b0, mag_q[31:8]} + {24'd0, round_up};
  assign exp_rnd  = exp_q + {7'd0, mant_sum[24]};

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    sgnin_d  = sgnin_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mag_d   = a;
          sgnin_d = is_signed;
          state_d = S_ABS;
        end
      end

      S_ABS: begin
        sign_d = sgnin_q & mag_q[31];
        mag_d  = mag_abs;
        exp_d  = 8'd158;
        cnt_d  = '0;
        if (mag_abs == '0) begin
          result_d = '0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        // A nonzero magnitude has its MSB set after at most 31 shifts,
        // so the counter bound is a backstop, not a functional exit.
        if (mag_q[31] || cnt_q == 5'd31) begin
          state_d = S_ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_ROUND: begin
        result_d = {sign_q, exp_rnd, mant_sum[24] ? 23'd0 : mant_sum[22:0]};
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mag_q    <= '0;
      sgnin_q  <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      sgnin_q  <= sgnin_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = (state_q != S_IDLE);

endmodule
